// File: rtl/alu_seq_pkg.sv
// Shared op codes, FSM state encoding and op-class helper for the OSECPU ALU.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_seq_pkg;

    localparam logic [3:0] ALU_OR  = 4'h0;
    localparam logic [3:0] ALU_XOR = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_ADD = 4'h4;
    localparam logic [3:0] ALU_SUB = 4'h5;
    localparam logic [3:0] ALU_MUL = 4'h6;
    localparam logic [3:0] ALU_SHL = 4'h8;
    localparam logic [3:0] ALU_SAR = 4'h9;
    localparam logic [3:0] ALU_DIV = 4'hA;
    localparam logic [3:0] ALU_MOD = 4'hB;

    // EXEC is the one-cycle slot where single-cycle ops are evaluated from
    // the operand registers, so their result appears one clock after accept.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic is_divop(input logic [3:0] o);
        return (o == ALU_DIV) || (o == ALU_MOD);
    endfunction

endpackage

// File: rtl/alu_divider.sv
// Unsigned restoring divider: one quotient bit per clock.
// Latency: start edge loads, WIDTH iteration edges, done pulses for one cycle after the last.
// Backpressure: none; start is only honoured while idle, results hold until the next start.
module alu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        rem_sh = {remainder, quotient[WIDTH-1]};
        diff   = rem_sh - {1'b0, dsr};
    end

    // Iteration register: quotient shifts in from the dividend side, remainder restores on borrow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            dsr       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                busy      <= 1'b1;
                cnt       <= CW'(WIDTH - 1);
                dsr       <= divisor;
                quotient  <= dividend;
                remainder <= '0;
            end else if (busy) begin
                if (!diff[WIDTH]) begin
                    remainder <= diff[WIDTH-1:0];
                    quotient  <= {quotient[WIDTH-2:0], 1'b1};
                end else begin
                    remainder <= rem_sh[WIDTH-1:0];
                    quotient  <= {quotient[WIDTH-2:0], 1'b0};
                end
                if (cnt == '0) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked integer ALU: logic, add/sub, mul, shifts and signed div/mod.
// Latency: 1 clock after accept; DIV/MOD with nonzero divisor WIDTH+2 clocks.
// Backpressure: result holds until out_ready; in_ready low while busy or a result is pending.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             div_zero,
    output logic             bad_op
);
    state_t           state, state_nxt;
    logic             accept;
    logic             div_start;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] d0_r, d1_r;
    logic             neg_q, neg_r;
    logic [WIDTH-1:0] abs0, abs1;
    logic             div_busy, div_done;
    logic [WIDTH-1:0] uq, ur;
    logic [WIDTH-1:0] exec_res, fix_res;
    logic             exec_dz, exec_bad;

    assign out_valid = (state == ST_DONE);
    assign in_ready  = (state == ST_IDLE) && !out_valid && !reset;
    assign accept    = in_valid && in_ready;
    assign div_start = accept && is_divop(op) && (d1 != '0);
    assign abs0      = d0[WIDTH-1] ? -d0 : d0;
    assign abs1      = d1[WIDTH-1] ? -d1 : d1;

    alu_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (abs0),
        .divisor   (abs1),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (uq),
        .remainder (ur)
    );

    // State register; reset aborts any divide in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state: divides with a real divisor take the iterative path, all else one EXEC cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = div_start ? ST_DIV : ST_EXEC;
            ST_EXEC: state_nxt = ST_DONE;
            ST_DIV:  if (div_done) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operands and result signs are captured once at accept; later input changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r  <= '0;
            d0_r  <= '0;
            d1_r  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            op_r  <= op;
            d0_r  <= d0;
            d1_r  <= d1;
            neg_q <= d0[WIDTH-1] ^ d1[WIDTH-1];
            neg_r <= d0[WIDTH-1];
        end
    end

    // Single-cycle result mux; DIV/MOD only reach here when the divisor is zero.
    always_comb begin
        exec_res = '0;
        exec_dz  = 1'b0;
        exec_bad = 1'b0;
        case (op_r)
            ALU_OR:  exec_res = d0_r | d1_r;
            ALU_XOR: exec_res = d0_r ^ d1_r;
            ALU_AND: exec_res = d0_r & d1_r;
            ALU_ADD: exec_res = d0_r + d1_r;
            ALU_SUB: exec_res = d0_r - d1_r;
            ALU_MUL: exec_res = d0_r * d1_r;
            ALU_SHL: exec_res = d0_r << d1_r[SHW-1:0];
            ALU_SAR: exec_res = $signed(d0_r) >>> d1_r[SHW-1:0];
            ALU_DIV,
            ALU_MOD: exec_dz  = 1'b1;
            default: exec_bad = 1'b1;
        endcase
    end

    // Sign fix for the magnitude divider: quotient sign s0^s1, remainder follows the dividend.
    always_comb begin
        fix_res = '0;
        if (op_r == ALU_DIV) fix_res = neg_q ? -uq : uq;
        else                 fix_res = neg_r ? -ur : ur;
    end

    // Output registers load only on the edge entering DONE, so they stay stable under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout     <= '0;
            div_zero <= 1'b0;
            bad_op   <= 1'b0;
        end else if (state == ST_EXEC) begin
            dout     <= exec_res;
            div_zero <= exec_dz;
            bad_op   <= exec_bad;
        end else if (state == ST_FIX) begin
            dout     <= fix_res;
            div_zero <= 1'b0;
            bad_op   <= 1'b0;
        end
    end

    // The divider must be running or just finishing whenever the FSM waits on it.
    a_div_alive: assert property (@(posedge clk) disable iff (reset)
        (state == ST_DIV) |-> (div_busy || div_done));

endmodule
